// File: rtl/led_pwm_pkg.sv
// Shared types and helpers for the N-channel PWM LED fader.
package led_pwm_pkg;

  typedef enum logic [1:0] {
    MODE_SET     = 2'd0,
    MODE_FADE    = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_OFF     = 2'd3
  } mode_e;

  function automatic int clog2_min1(input int value);
    return ($clog2(value) < 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One PWM channel: shadow config, boundary-applied duty, fade/breathe stepping.
module led_pwm_channel
  import led_pwm_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clki,
  input  logic                rst_n,
  input  logic                wr_en,
  input  mode_e               wr_mode,
  input  logic [PWM_BITS-1:0] wr_duty,
  input  logic                boundary,
  input  logic                ramp_step,
  input  logic [PWM_BITS-1:0] cnt,
  output logic                pwm,
  output logic                busy
);

  mode_e               shadow_mode_reg, mode_reg, mode_next;
  logic [PWM_BITS-1:0] shadow_target_reg, target_reg, target_next;
  logic [PWM_BITS-1:0] cur_duty_reg, cur_duty_next;
  logic                pend_reg, dir_up_reg, dir_up_next, pwm_reg;

  // Pending loads are resolved first so the ramp step sees the new mode/target.
  always_comb begin
    mode_next     = mode_reg;
    target_next   = target_reg;
    cur_duty_next = cur_duty_reg;
    dir_up_next   = dir_up_reg;
    if (boundary && pend_reg) begin
      mode_next   = shadow_mode_reg;
      target_next = shadow_target_reg;
      case (shadow_mode_reg)
        MODE_SET:     cur_duty_next = shadow_target_reg;
        MODE_OFF:     cur_duty_next = '0;
        MODE_BREATHE: dir_up_next = 1'b1;
        default:      ;
      endcase
    end
    if (ramp_step) begin
      case (mode_next)
        MODE_FADE: begin
          if (cur_duty_next < target_next)
            cur_duty_next = cur_duty_next + 1'b1;
          else if (cur_duty_next > target_next)
            cur_duty_next = cur_duty_next - 1'b1;
        end
        MODE_BREATHE: begin
          if (dir_up_next) begin
            if (cur_duty_next < target_next) begin
              cur_duty_next = cur_duty_next + 1'b1;
            end else begin
              dir_up_next = 1'b0;
              if (cur_duty_next != '0) cur_duty_next = cur_duty_next - 1'b1;
            end
          end else begin
            if (cur_duty_next != '0) begin
              cur_duty_next = cur_duty_next - 1'b1;
            end else begin
              dir_up_next = 1'b1;
              if (target_next != '0) cur_duty_next = cur_duty_next + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      shadow_mode_reg   <= MODE_OFF;
      shadow_target_reg <= '0;
      pend_reg          <= 1'b0;
      mode_reg          <= MODE_OFF;
      target_reg        <= '0;
      cur_duty_reg      <= '0;
      dir_up_reg        <= 1'b1;
      pwm_reg           <= 1'b0;
    end else begin
      if (wr_en) begin
        shadow_mode_reg   <= wr_mode;
        shadow_target_reg <= wr_duty;
        pend_reg          <= 1'b1;
      end else if (boundary) begin
        pend_reg <= 1'b0;
      end
      mode_reg     <= mode_next;
      target_reg   <= target_next;
      cur_duty_reg <= cur_duty_next;
      dir_up_reg   <= dir_up_next;
      pwm_reg      <= (cnt < cur_duty_reg);
    end
  end

  assign pwm  = pwm_reg;
  assign busy = pend_reg || ((mode_reg == MODE_FADE) && (cur_duty_reg != target_reg))
                || (mode_reg == MODE_BREATHE);

endmodule

// File: rtl/led_pwm_fader.sv
// N-channel PWM LED controller: shared prescaler, PWM counter, ramp timer, write decode.
module led_pwm_fader
  import led_pwm_pkg::*;
#(
  parameter  int CHANNELS     = 3,
  parameter  int PWM_BITS     = 8,
  parameter  int PRESCALE     = 94,
  parameter  int RAMP_PERIODS = 4,
  localparam int CW           = clog2_min1(CHANNELS)
) (
  input  logic                clki,
  input  logic                rst_n,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [CW-1:0]       wr_ch,
  input  logic [1:0]          wr_mode,
  input  logic [PWM_BITS-1:0] wr_duty,
  output logic [CHANNELS-1:0] pwm_out,
  output logic [CHANNELS-1:0] busy,
  output logic                period_start
);

  localparam int PSW = clog2_min1(PRESCALE);
  localparam int RW  = clog2_min1(RAMP_PERIODS);
  // Counter stops one short of all-ones so a full-scale duty is constantly high.
  localparam logic [PWM_BITS-1:0] CNT_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

  logic [PSW-1:0]      presc_reg;
  logic [PWM_BITS-1:0] cnt_reg;
  logic [RW-1:0]       ramp_cnt_reg;
  logic                period_start_reg, wr_ready_reg;
  logic                tick, boundary, ramp_wrap, ramp_step;
  logic [CHANNELS-1:0] wr_en;

  assign tick      = (presc_reg == PSW'(PRESCALE - 1));
  assign boundary  = tick && (cnt_reg == CNT_LAST);
  assign ramp_wrap = (ramp_cnt_reg == RW'(RAMP_PERIODS - 1));
  assign ramp_step = boundary && ramp_wrap;

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg        <= '0;
      cnt_reg          <= '0;
      ramp_cnt_reg     <= '0;
      period_start_reg <= 1'b0;
      wr_ready_reg     <= 1'b0;
    end else begin
      wr_ready_reg     <= 1'b1;
      period_start_reg <= boundary;
      presc_reg        <= tick ? '0 : presc_reg + 1'b1;
      if (tick) cnt_reg <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
      if (boundary) ramp_cnt_reg <= ramp_wrap ? '0 : ramp_cnt_reg + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      // Out-of-range channel numbers match no instance and are silently dropped.
      assign wr_en[gi] = wr_valid && wr_ready_reg && (wr_ch == CW'(gi));

      led_pwm_channel #(.PWM_BITS(PWM_BITS)) u_channel (
        .clki      (clki),
        .rst_n     (rst_n),
        .wr_en     (wr_en[gi]),
        .wr_mode   (mode_e'(wr_mode)),
        .wr_duty   (wr_duty),
        .boundary  (boundary),
        .ramp_step (ramp_step),
        .cnt       (cnt_reg),
        .pwm       (pwm_out[gi]),
        .busy      (busy[gi])
      );
    end
  endgenerate

  assign wr_ready     = wr_ready_reg;
  assign period_start = period_start_reg;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench: two faders (ramp 2 and ramp 1) sharing one write bus, 4-bit PWM.
module tb_led_pwm_fader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid;
  logic [1:0] wr_ch;
  logic [1:0] wr_mode;
  logic [3:0] wr_duty;
  logic       wr_ready_a, wr_ready_b, ps_a, ps_b;
  logic [2:0] pwm_a, pwm_b, busy_a, busy_b;

  int checks = 0;
  int errors = 0;
  int hi_a[3];
  int hi_b[3];

  always #5 clk = ~clk;

  led_pwm_fader #(.CHANNELS(3), .PWM_BITS(4), .PRESCALE(1), .RAMP_PERIODS(2)) u_dut (
    .clki(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready_a),
    .wr_ch(wr_ch), .wr_mode(wr_mode), .wr_duty(wr_duty),
    .pwm_out(pwm_a), .busy(busy_a), .period_start(ps_a)
  );

  led_pwm_fader #(.CHANNELS(3), .PWM_BITS(4), .PRESCALE(1), .RAMP_PERIODS(1)) u_dut_b (
    .clki(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready_b),
    .wr_ch(wr_ch), .wr_mode(wr_mode), .wr_duty(wr_duty),
    .pwm_out(pwm_b), .busy(busy_b), .period_start(ps_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_write(input int ch, input int mode, input int duty);
    logic [31:0] ch_v, mode_v, duty_v;
    ch_v = ch; mode_v = mode; duty_v = duty;
    wr_valid = 1'b1;
    wr_ch    = ch_v[1:0];
    wr_mode  = mode_v[1:0];
    wr_duty  = duty_v[3:0];
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    $display("write ch=%0d mode=%0d duty=%0d", ch, mode, duty);
  endtask

  // Advance to the next negedge at which period_start is high.
  task automatic sync_period;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ps_a) return;
    end
    check("sync_timeout", 32'd0, 32'd1);
  endtask

  // Count high cycles of the period whose period_start is current; ends on the next one.
  task automatic meas;
    for (int c = 0; c < 3; c++) begin
      hi_a[c] = 0;
      hi_b[c] = 0;
    end
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        hi_a[c] += int'(pwm_a[c]);
        hi_b[c] += int'(pwm_b[c]);
      end
    end
    check("period_align", ps_a, 1);
    check("period_ab", ps_b, ps_a);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fade_up[6];
    int fade_dn[7];
    int breathe[8];
    fade_up = '{2, 3, 3, 4, 4, 5};
    fade_dn = '{4, 4, 3, 3, 2, 2, 1};
    breathe = '{0, 1, 2, 3, 2, 1, 0, 1};

    rst_n = 1'b0; wr_valid = 1'b0; wr_ch = '0; wr_mode = '0; wr_duty = '0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("rst_pwm", pwm_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_ready", wr_ready_a, 0);
      check("rst_ps", ps_a, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_rise", wr_ready_a, 1);
    check("idle_busy", busy_a, 0);
    sync_period();                                  // P1

    do_write(0, 0, 0);
    do_write(1, 0, 5);
    do_write(2, 0, 15);
    check("set_pend_busy", busy_a, 3'b111);
    sync_period();                                  // P2
    meas();
    check("set_ch0", hi_a[0], 0);
    check("set_ch1", hi_a[1], 5);
    check("set_ch2", hi_a[2], 15);
    check("set_b_ch1", hi_b[1], 5);
    check("set_busy_clear", busy_a, 0);

    do_write(1, 0, 3);                              // P3
    do_write(1, 0, 9);
    check("lww_busy", busy_a[1], 1);
    sync_period();                                  // P4
    check("lww_busy_clear", busy_a[1], 0);
    meas();
    check("lww_ch1", hi_a[1], 9);

    do_write(3, 0, 7);                              // P5
    check("badch_busy", busy_a, 0);
    do_write(0, 0, 2);
    sync_period();                                  // P6
    do_write(0, 1, 5);
    check("coinc_busy", busy_a[0], 1);
    meas();
    check("coinc_ch0", hi_a[0], 2);
    check("badch_ch1", hi_a[1], 9);
    check("badch_ch2", hi_a[2], 15);

    for (int k = 0; k < 6; k++) begin               // P7..P12
      check("fade_up_busy", busy_a[0], (k < 5) ? 1 : 0);
      meas();
      check("fade_up_duty", hi_a[0], fade_up[k]);
    end

    do_write(0, 1, 1);                              // P13
    sync_period();                                  // P14
    for (int k = 0; k < 7; k++) begin
      meas();
      check("fade_dn_duty", hi_a[0], fade_dn[k]);
    end
    check("fade_dn_busy", busy_a[0], 0);            // P21

    do_write(2, 3, 0);
    sync_period();                                  // P22
    for (int k = 0; k < 8; k++) begin
      if (k == 0) do_write(2, 2, 3);
      else check("breathe_busy", busy_b[2], 1);
      meas();
      check("breathe_duty", hi_b[2], breathe[k]);
    end

    do_write(2, 3, 0);                              // P30
    sync_period();                                  // P31
    do_write(2, 2, 0);
    for (int k = 0; k < 4; k++) begin
      meas();
      check("breathe0_duty", hi_b[2], 0);
    end
    check("breathe0_busy", busy_b[2], 1);

    do_write(0, 1, 15);                             // P35
    sync_period();                                  // P36
    @(negedge clk);
    check("midfade_pwm", pwm_a[0], 1);
    check("midfade_busy", busy_a[0], 1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_pwm", pwm_a, 0);
    check("arst_busy", busy_a, 0);
    check("arst_ready", wr_ready_a, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rerst_ready", wr_ready_a, 1);
    sync_period();
    meas();
    check("rerst_ch0", hi_a[0], 0);
    check("rerst_ch1", hi_a[1], 0);
    check("rerst_busy", busy_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
